// File: rtl/toy_mips_pkg.sv
// toy_mips_pkg: shared opcodes, functs, ALU operations and default memory sizes for the toy MIPS core
package toy_mips_pkg;
  localparam int IMEM_BYTES_DEFAULT = 256;
  localparam int DMEM_WORDS_DEFAULT = 64;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;
  localparam logic [31:0] HALT_INSTR = 32'h0000003f;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
endpackage

// File: rtl/toy_mips_alu.sv
// toy_mips_alu: combinational ALU with a zero flag used for beq
module toy_mips_alu import toy_mips_pkg::*; (
  input logic [31:0] a,
  input logic [31:0] b,
  input alu_op_t op,
  output logic [31:0] result,
  output logic zero
);
  always_comb begin
    result = op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b :
             op == ALU_OR  ? a | b :
             op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
    zero = result == 32'd0;
  end
endmodule

// File: rtl/toy_mips_processor.sv
// toy_mips_processor: single-cycle MIPS subset core; define TOY_MIPS_JUMP_EN to enable j/jal/jr
module toy_mips_processor import toy_mips_pkg::*; #(
  parameter int IMEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter int DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input logic clk,
  input logic reset,
  output logic halted
);
  localparam int IW = $clog2(IMEM_BYTES);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [7:0] instruction_memory [0:IMEM_BYTES-1];
  logic [31:0] data_memory [0:DMEM_WORDS-1];
  logic [31:0] registers [0:31];
  logic [31:0] pc, instruction, pc_plus4, pc_next, rs_val, rt_val, imm_sext, alu_b, alu_result, wb_data;
  logic [IW-1:0] fa;
  logic [DW-1:0] mem_idx;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, wb_reg;
  logic wb_en, mem_we, halt, alu_zero, r_known;
  alu_op_t alu_op;

  assign fa = pc[IW-1:0];
  assign instruction = {instruction_memory[fa], instruction_memory[fa + IW'(1)],
                        instruction_memory[fa + IW'(2)], instruction_memory[fa + IW'(3)]};
  assign op = instruction[31:26];
  assign rs = instruction[25:21];
  assign rt = instruction[20:16];
  assign rd = instruction[15:11];
  assign funct = instruction[5:0];
  assign imm_sext = {{16{instruction[15]}}, instruction[15:0]};
  assign rs_val = rs == 5'd0 ? 32'd0 : registers[rs];
  assign rt_val = rt == 5'd0 ? 32'd0 : registers[rt];
  assign pc_plus4 = pc + 32'd4;
  assign halt = instruction == HALT_INSTR;
  assign r_known = funct inside {F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_SLT};
  assign mem_idx = alu_result[DW+1:2];
  assign mem_we = op == OP_SW;

  always_comb begin
    alu_op = op == OP_RTYPE ? (funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND :
                               funct == F_OR ? ALU_OR : funct == F_SLT ? ALU_SLT : ALU_ADD) :
             op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_BEQ ? ALU_SUB : ALU_ADD;
    alu_b = (op == OP_RTYPE || op == OP_BEQ) ? rt_val :
            (op == OP_ANDI || op == OP_ORI) ? {16'd0, instruction[15:0]} : imm_sext;
  end

  toy_mips_alu alu (.a(rs_val), .b(alu_b), .op(alu_op), .result(alu_result), .zero(alu_zero));

  always_comb begin
    wb_en = (op == OP_RTYPE && r_known) || op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LW};
    wb_reg = op == OP_RTYPE ? rd : rt;
    wb_data = op == OP_LW ? data_memory[mem_idx] : alu_result;
    pc_next = (op == OP_BEQ && alu_zero) ? pc_plus4 + (imm_sext << 2) : pc_plus4;
`ifdef TOY_MIPS_JUMP_EN
    if (op == OP_JAL) begin
      wb_en = 1'b1;
      wb_reg = 5'd31;
      wb_data = pc_plus4;
    end
    if (op == OP_J || op == OP_JAL) pc_next = {pc_plus4[31:28], instruction[25:0], 2'b00};
    if (op == OP_RTYPE && funct == F_JR) pc_next = rs_val;
`endif
    if (halt || halted) pc_next = pc;
  end

  // register, memory and pc updates all commit on the same edge; reset blocks every write
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= 32'd0;
      halted <= 1'b0;
    end else begin
      pc <= pc_next;
      halted <= halted | halt;
      if (!halted && wb_en && wb_reg != 5'd0) registers[wb_reg] <= wb_data;
      if (!halted && mem_we) data_memory[mem_idx] <= rt_val;
    end
  end
endmodule

// File: tb/tb_toy_mips_processor.sv
// tb_toy_mips_processor: directed and random programs checked against an instruction-level model
module tb_toy_mips_processor;
`ifdef TOY_MIPS_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif
  logic clk, reset, halted;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] prog [$];
  logic [31:0] trace [$];
  logic [31:0] m_reg [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_pc;

  toy_mips_processor dut (.clk(clk), .reset(reset), .halted(halted));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction
  function automatic logic [31:0] rdreg(input logic [4:0] r);
    return r == 5'd0 ? 32'd0 : m_reg[r];
  endfunction

  task automatic init_state(input bit rnd);
    for (int i = 0; i < 32; i++) m_reg[i] = (rnd && i != 0) ? $urandom : 32'd0;
    for (int i = 0; i < 64; i++) m_dmem[i] = rnd ? $urandom : 32'd0;
  endtask

  // executes the program one instruction at a time, recording the pc of each executed instruction
  task automatic model_run();
    logic [31:0] ins, s, t, simm, nxt, v;
    logic [4:0] wr;
    bit we;
    int unsigned idx;
    m_pc = 0;
    trace.delete();
    for (int n = 0; n < 2000; n++) begin
      idx = (m_pc % 256) / 4;
      ins = idx < prog.size() ? prog[idx] : 32'd0;
      trace.push_back(m_pc);
      if (ins == 32'h3f) break;
      s = rdreg(ins[25:21]);
      t = rdreg(ins[20:16]);
      simm = {{16{ins[15]}}, ins[15:0]};
      nxt = m_pc + 4;
      we = 0;
      wr = ins[20:16];
      v = 0;
      case (ins[31:26])
        6'h00: begin
          we = 1;
          wr = ins[15:11];
          case (ins[5:0])
            6'h20, 6'h21: v = s + t;
            6'h22: v = s - t;
            6'h24: v = s & t;
            6'h25: v = s | t;
            6'h2a: v = {31'd0, $signed(s) < $signed(t)};
            default: begin
              we = 0;
              if (JUMP_EN && ins[5:0] == 6'h08) nxt = s;
            end
          endcase
        end
        6'h08: begin we = 1; v = s + simm; end
        6'h0c: begin we = 1; v = s & {16'd0, ins[15:0]}; end
        6'h0d: begin we = 1; v = s | {16'd0, ins[15:0]}; end
        6'h23: begin we = 1; v = m_dmem[((s + simm) >> 2) % 64]; end
        6'h2b: m_dmem[((s + simm) >> 2) % 64] = t;
        6'h04: if (s == t) nxt = m_pc + 4 + (simm << 2);
        6'h02, 6'h03: if (JUMP_EN) begin
          nxt = {nxt[31:28], ins[25:0], 2'b00};
          if (ins[31:26] == 6'h03) begin we = 1; wr = 5'd31; v = m_pc + 4; end
        end
        default: ;
      endcase
      if (we && wr != 5'd0) m_reg[wr] = v;
      m_pc = nxt;
    end
  endtask

  task automatic load_dut();
    logic [31:0] w;
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      w = (i / 4) < prog.size() ? prog[i / 4] : 32'd0;
      dut.instruction_memory[i] <= 8'(w >> (24 - 8 * (i % 4)));
    end
    for (int i = 0; i < 32; i++) dut.registers[i] <= m_reg[i];
    for (int i = 0; i < 64; i++) dut.data_memory[i] <= m_dmem[i];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_prog(input string name);
    logic [31:0] last;
    load_dut();
    check({name, ":reset_pc"}, dut.pc, 32'd0);
    check({name, ":reset_halted"}, 32'(halted), 32'd0);
    model_run();
    reset = 1;
    foreach (trace[k]) begin
      check($sformatf("%s:pc[%0d]", name, k), dut.pc, trace[k]);
      check($sformatf("%s:running[%0d]", name, k), 32'(halted), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    last = trace[trace.size() - 1];
    check({name, ":halted"}, 32'(halted), 32'd1);
    check({name, ":halt_pc"}, dut.pc, last);
    repeat (3) @(negedge clk);
    check({name, ":sticky_halted"}, 32'(halted), 32'd1);
    check({name, ":frozen_pc"}, dut.pc, last);
    check({name, ":halt_instr"}, dut.instruction, 32'h3f);
    for (int i = 0; i < 32; i++) check($sformatf("%s:reg%0d", name, i), dut.registers[i], rdreg(5'(i)));
    for (int i = 0; i < 64; i++) check($sformatf("%s:dmem%0d", name, i), dut.data_memory[i], m_dmem[i]);
  endtask

  task automatic gen_random(input int n);
    int fns [6] = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h2a};
    int a, b, c;
    prog.delete();
    for (int i = 0; i < n - 1; i++) begin
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      case ($urandom_range(0, 8))
        0, 1: prog.push_back(enc_r(a, b, c, fns[$urandom_range(0, 5)]));
        2: prog.push_back(enc_i('h08, a, b, $urandom));
        3: prog.push_back(enc_i($urandom_range(0, 1) ? 'h0c : 'h0d, a, b, $urandom));
        4: prog.push_back(enc_i('h23, a, b, $urandom));
        5: prog.push_back(enc_i('h2b, a, b, $urandom));
        6: prog.push_back(enc_i('h04, a, $urandom_range(0, 1) ? a : b, $urandom_range(0, n - 2 - i)));
        7: prog.push_back(enc_j($urandom_range(2, 3), $urandom_range(i + 1, n - 1)));
        default: prog.push_back($urandom_range(0, 1) ? enc_i('h3e, a, b, $urandom) :
                                enc_r(a, b, c, JUMP_EN ? 'h01 : 'h08));
      endcase
    end
    prog.push_back(32'h3f);
  endtask

  initial begin
    reset = 0;
    init_state(0);
    prog = '{32'h3f};
    run_prog("halt0");

    init_state(0);
    prog = '{enc_i('h08, 0, 1, 5), enc_i('h08, 0, 2, -3), enc_r(1, 2, 3, 'h20),
             enc_r(1, 2, 4, 'h22), enc_r(2, 1, 5, 'h2a), 32'h3f};
    run_prog("arith");
    check("arith:r3", dut.registers[3], 32'd2);
    check("arith:r4", dut.registers[4], 32'd8);
    check("arith:r5", dut.registers[5], 32'd1);

    init_state(0);
    prog = '{enc_i('h08, 0, 1, 'h1234), enc_i('h2b, 0, 1, 8), enc_i('h23, 0, 2, 8), 32'h3f};
    run_prog("mem");
    check("mem:dmem2", dut.data_memory[2], 32'h1234);
    check("mem:r2", dut.registers[2], 32'h1234);

    init_state(0);
    prog = '{enc_i('h08, 0, 1, 1), enc_i('h04, 1, 0, 1), enc_i('h08, 0, 2, 7),
             enc_i('h04, 0, 0, 1), enc_i('h08, 0, 3, 9), 32'h3f};
    run_prog("branch");
    check("branch:r2", dut.registers[2], 32'd7);
    check("branch:r3", dut.registers[3], 32'd0);

    init_state(1);
    prog = '{enc_i('h08, 0, 0, 5), enc_r(0, 0, 1, 'h20), 32'h3f};
    run_prog("zero");
    check("zero:r0", dut.registers[0], 32'd0);
    check("zero:r1", dut.registers[1], 32'd0);

`ifdef TOY_MIPS_JUMP_EN
    init_state(0);
    prog = '{enc_j('h03, 4), enc_i('h08, 0, 2, 1), enc_i('h08, 0, 2, 1), enc_i('h08, 0, 2, 1), 32'h3f};
    run_prog("jal");
    check("jal:r31", dut.registers[31], 32'd4);
    check("jal:pc", dut.pc, 32'h10);
    check("jal:r2", dut.registers[2], 32'd0);
`endif

    init_state(0);
    prog = '{enc_i('h08, 0, 1, 3), enc_i('h04, 0, 0, -1)};
    load_dut();
    reset = 1;
    repeat (6) @(negedge clk);
    check("loop:pc", dut.pc, 32'd4);
    check("loop:running", 32'(halted), 32'd0);
    check("loop:r1", dut.registers[1], 32'd3);
    reset = 0;
    @(negedge clk);
    check("midreset:pc", dut.pc, 32'd0);
    check("midreset:r1_kept", dut.registers[1], 32'd3);
    reset = 1;
    @(negedge clk);
    check("restart:pc", dut.pc, 32'd4);

    for (int p = 0; p < 30; p++) begin
      init_state(1);
      gen_random($urandom_range(8, 24));
      run_prog($sformatf("rand%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/toy_mips_processor.md
# toy_mips_processor

Single-cycle, 32-bit MIPS-subset processor with an on-chip byte-addressed instruction memory, a word-addressed data memory and a 32-entry register file. It is a self-contained top level. The bench preloads the memories hierarchically, releases reset, and watches `pc`, `instruction` and `halted` until a halt instruction executes. Module name: `toy_mips_processor`.

## Interface
- `IMEM_BYTES`, 256: instruction memory size in bytes (64 instructions).
- `DMEM_WORDS`, 64: data memory size in 32-bit words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `halted` output 1: high once a halt instruction has executed.

Bench-visible internal signals, names fixed:
- `instruction_memory[0:IMEM_BYTES-1]`, 8-bit entries.
- `data_memory[0:DMEM_WORDS-1]`, 32-bit entries.
- `registers[0:31]`, 32-bit entries.
- `pc`, 32 bits.
- `instruction`, 32 bits.

## Operation
- Fetch is big-endian and combinational: `instruction = {imem[pc], imem[pc+1], imem[pc+2], imem[pc+3]}`. `pc` is used modulo `IMEM_BYTES`.
- Decode uses standard MIPS fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0].
- R-type (op 0x00), writes rd:
  - add 0x20 and addu 0x21: wrapping sum, no overflow trap.
  - sub 0x22: wrapping difference.
  - and 0x24, or 0x25.
  - slt 0x2a: signed compare.
- Halt: exactly 0x0000003f (op 0, funct 0x3f). It sets `halted` and freezes `pc`. No further register or memory writes occur.
- I-type, writes rt:
  - addi 0x08: sign-extended immediate.
  - andi 0x0c and ori 0x0d: zero-extended immediate.
  - lw 0x23: rt = dmem[(rs+sext(imm))[7:2]]; address bits [1:0] are ignored.
- sw 0x2b: dmem[(rs+sext(imm))[7:2]] = rt. Address index wraps modulo `DMEM_WORDS`.
- beq 0x04: if rs==rt, pc = pc+4+(sext(imm)<<2).
- Register 0 always reads 0. Writes to it are discarded.
- An unknown opcode or funct acts as a NOP (pc += 4).
- Register file and data memory are not cleared by reset; the bench initialises them.

## Timing
- Every instruction, including lw and sw, completes in one cycle.
- On the rising edge, the register write, memory write and pc update all commit together.
- Register and memory reads are combinational and return the pre-edge value. lw followed by a dependent instruction therefore needs no stall.
- Reset (`reset`=0 at an edge): pc=0 and `halted`=0. Reset overrides any instruction, including halt.
- Reset asserted mid-program restarts at pc 0. Registers and data memory keep their contents.
- `halted`=1 is sticky until reset. While halted, `instruction` continues to show 0x0000003f.
- A branch or jump to itself loops forever. This is legal.

## Configuration
- `TOY_MIPS_JUMP_EN`:
  - Defined: j (op 0x02) and jal (op 0x03) are supported.
    - Target pc = {pc+4[31:28], target, 2'b00}.
    - jal also writes pc+4 to $31.
    - jr (op 0, funct 0x08) is also supported: pc = rs.
  - Undefined: j, jal and jr decode as NOPs.

## Structure
- A shared package `toy_mips_pkg` holds:
  - opcode and funct localparams (including HALT_INSTR = 32'h0000003f);
  - the ALU-op enum;
  - the `IMEM_BYTES` and `DMEM_WORDS` defaults.
- One sub-module `toy_mips_alu`: combinational, inputs a, b and op, output result plus a zero flag.
- Fetch, decode, register file, data memory and pc logic live in the top level.

## Test plan
- Reset then halt: imem word0 = 0000003f. After reset release, `halted`=1 within one cycle, pc stays 0, all registers stay 0.
- Arithmetic: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1; halt -> $3=2, $4=8, $5=1.
- Memory: addi $1,$0,0x1234; sw $1,8($0); lw $2,8($0); halt -> dmem[2]=00001234, $2=00001234.
- Branch: addi $1,$0,1; beq $1,$0,+1; addi $2,$0,7; beq $0,$0,+1; addi $3,$0,9; halt -> $2=7, $3=0.
- $0 protection: addi $0,$0,5; add $1,$0,$0; halt -> $0=0, $1=0.
- With `TOY_MIPS_JUMP_EN`: jal to the halt at byte address 0x10 from pc 0 -> $31=00000004, pc=0x10, `halted`=1.
